// File: rtl/program_loader_if.sv
// Host-link and memory-write bundle for the program loader.
// The slave modport is the loader itself; the master modport is the host/bench side.
interface program_loader_if;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [4:0]  dmem_addr_o;
  logic [7:0]  dmem_data_o;
  logic        start_o;
  logic        err_o;
  logic        chk_err_o;

  modport slave (
    input  data_i, valid_i,
    output ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           start_o, err_o, chk_err_o
  );

  modport master (
    output data_i, valid_i,
    input  ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           start_o, err_o, chk_err_o
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: parses 'I'/'D' load frames into instruction-word and
// data-byte writes, and 'G'/'S' commands into the CPU start level. All outputs are
// registered, so every write strobe, error pulse and start change appears in the
// cycle after the byte that caused it is accepted.
module program_loader (
  input  logic             clk_i,
  input  logic             rst_i,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ADDR, CNT, PAYLOAD, CHK} state_t;

  state_t      state_q, state_d;
  logic        isInstr_q, isInstr_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  count_q, count_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  chkAcc_q, chkAcc_d;
  logic        ready_q, ready_d;
  logic        start_q, start_d;
  logic        err_q, err_d;
  logic        chkErr_q, chkErr_d;
  logic        imemWe_q, imemWe_d;
  logic [7:0]  imemAddr_q, imemAddr_d;
  logic [31:0] imemData_q, imemData_d;
  logic        dmemWe_q, dmemWe_d;
  logic [4:0]  dmemAddr_q, dmemAddr_d;
  logic [7:0]  dmemData_q, dmemData_d;

  logic       accept;
  logic [8:0] dmemEnd;

  assign accept  = bus.valid_i && ready_q;
  assign dmemEnd = {4'b0000, addr_q[4:0]} + {1'b0, bus.data_i};

  assign bus.ready_o     = ready_q;
  assign bus.start_o     = start_q;
  assign bus.err_o       = err_q;
  assign bus.chk_err_o   = chkErr_q;
  assign bus.imem_we_o   = imemWe_q;
  assign bus.imem_addr_o = imemAddr_q;
  assign bus.imem_data_o = imemData_q;
  assign bus.dmem_we_o   = dmemWe_q;
  assign bus.dmem_addr_o = dmemAddr_q;
  assign bus.dmem_data_o = dmemData_q;

  // State register; reset drops any partial frame and releases nothing to the CPU.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      isInstr_q  <= 1'b0;
      addr_q     <= 8'h00;
      count_q    <= 9'd0;
      byteIdx_q  <= 2'd0;
      word_q     <= 24'h000000;
      chkAcc_q   <= 8'h00;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      chkErr_q   <= 1'b0;
      imemWe_q   <= 1'b0;
      imemAddr_q <= 8'h00;
      imemData_q <= 32'h00000000;
      dmemWe_q   <= 1'b0;
      dmemAddr_q <= 5'd0;
      dmemData_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      isInstr_q  <= isInstr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      byteIdx_q  <= byteIdx_d;
      word_q     <= word_d;
      chkAcc_q   <= chkAcc_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      err_q      <= err_d;
      chkErr_q   <= chkErr_d;
      imemWe_q   <= imemWe_d;
      imemAddr_q <= imemAddr_d;
      imemData_q <= imemData_d;
      dmemWe_q   <= dmemWe_d;
      dmemAddr_q <= dmemAddr_d;
      dmemData_q <= dmemData_d;
    end
  end

  // Frame parser: decides next state, pulses and write contents for each accepted byte.
  always_comb begin
    state_d    = state_q;
    isInstr_d  = isInstr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    byteIdx_d  = byteIdx_q;
    word_d     = word_q;
    chkAcc_d   = chkAcc_q;
    ready_d    = 1'b1;
    start_d    = start_q;
    err_d      = 1'b0;
    chkErr_d   = chkErr_q;
    imemWe_d   = 1'b0;
    imemAddr_d = imemAddr_q;
    imemData_d = imemData_q;
    dmemWe_d   = 1'b0;
    dmemAddr_d = dmemAddr_q;
    dmemData_d = dmemData_q;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (bus.data_i)
            8'h49, 8'h44: begin
              if (start_q) begin
                err_d = 1'b1;
              end else begin
                isInstr_d = (bus.data_i == 8'h49);
                state_d   = ADDR;
              end
            end
            8'h47:   start_d = 1'b1;
            8'h53:   start_d = 1'b0;
            default: err_d   = 1'b1;
          endcase
        end
        ADDR: begin
          if (!isInstr_q && (bus.data_i[7:5] != 3'b000)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = bus.data_i;
            state_d = CNT;
          end
        end
        CNT: begin
          if (!isInstr_q && ((bus.data_i == 8'h00) || (dmemEnd > 9'd32))) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            count_d   = (bus.data_i == 8'h00) ? 9'd256 : {1'b0, bus.data_i};
            byteIdx_d = 2'd0;
            chkAcc_d  = 8'h00;
            state_d   = PAYLOAD;
          end
        end
        PAYLOAD: begin
          chkAcc_d = chkAcc_q ^ bus.data_i;
          if (isInstr_q) begin
            word_d    = {bus.data_i, word_q[23:8]};
            byteIdx_d = byteIdx_q + 2'd1;
            if (byteIdx_q == 2'd3) begin
              imemWe_d   = 1'b1;
              imemAddr_d = addr_q;
              imemData_d = {bus.data_i, word_q};
              addr_d     = addr_q + 8'd1;
              count_d    = count_q - 9'd1;
              if (count_q == 9'd1) state_d = CHK;
            end
          end else begin
            dmemWe_d   = 1'b1;
            dmemAddr_d = addr_q[4:0];
            dmemData_d = bus.data_i;
            addr_d     = addr_q + 8'd1;
            count_d    = count_q - 9'd1;
            if (count_q == 9'd1) state_d = CHK;
          end
        end
        CHK: begin
          if (bus.data_i != chkAcc_q) begin
            err_d    = 1'b1;
            chkErr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes and error pulses are queued
// as bytes are sent, and a negedge monitor pops and compares each one the DUT emits.
module tb_program_loader;

  logic clk;
  logic rst_n;
  program_loader_if bus ();

  program_loader u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } evt_t;

  evt_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam int KIND_IMEM = 0;
  localparam int KIND_DMEM = 1;
  localparam int KIND_ERR  = 2;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkEvent(input int kind, input logic [7:0] addr, input logic [31:0] data);
    evt_t e;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected event kind=%0d addr=0x%02h data=0x%08h at %0t",
               kind, addr, data, $time);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.addr !== addr || e.data !== data) begin
        mismatched++;
        $display("[TB] FAIL event: got kind=%0d addr=0x%02h data=0x%08h, expected kind=%0d addr=0x%02h data=0x%08h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic expectImem(input logic [7:0] a, input logic [31:0] d);
    evt_t e;
    e.kind = KIND_IMEM; e.addr = a; e.data = d;
    expQ.push_back(e);
  endtask

  task automatic expectDmem(input logic [4:0] a, input logic [7:0] d);
    evt_t e;
    e.kind = KIND_DMEM; e.addr = {3'b000, a}; e.data = {24'h0, d};
    expQ.push_back(e);
  endtask

  task automatic expectErr();
    evt_t e;
    e.kind = KIND_ERR; e.addr = 8'h00; e.data = 32'h0;
    expQ.push_back(e);
  endtask

  // Presents one byte for exactly one accepting edge, returning #1 after that edge.
  task automatic applyStimulus(input logic [7:0] b);
    bus.data_i  = b;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] bytes[]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ready_o"},     {31'b0, bus.ready_o},   32'h0);
    checkOutput({tag, " start_o"},     {31'b0, bus.start_o},   32'h0);
    checkOutput({tag, " chk_err_o"},   {31'b0, bus.chk_err_o}, 32'h0);
    checkOutput({tag, " err_o"},       {31'b0, bus.err_o},     32'h0);
    checkOutput({tag, " imem_we_o"},   {31'b0, bus.imem_we_o}, 32'h0);
    checkOutput({tag, " dmem_we_o"},   {31'b0, bus.dmem_we_o}, 32'h0);
    checkOutput({tag, " imem_addr_o"}, {24'b0, bus.imem_addr_o}, 32'h0);
    checkOutput({tag, " imem_data_o"}, bus.imem_data_o,          32'h0);
    checkOutput({tag, " dmem_addr_o"}, {27'b0, bus.dmem_addr_o}, 32'h0);
    checkOutput({tag, " dmem_data_o"}, {24'b0, bus.dmem_data_o}, 32'h0);
  endtask

  // Monitor: every strobe or error pulse the DUT shows is matched against the queue.
  always @(negedge clk) begin
    if (bus.imem_we_o) checkEvent(KIND_IMEM, bus.imem_addr_o, bus.imem_data_o);
    if (bus.dmem_we_o) checkEvent(KIND_DMEM, {3'b000, bus.dmem_addr_o}, {24'h0, bus.dmem_data_o});
    if (bus.err_o)     checkEvent(KIND_ERR, 8'h00, 32'h0);
  end

  // Directed scenario sequence.
  initial begin
    rst_n       = 1'b0;
    bus.data_i  = 8'h00;
    bus.valid_i = 1'b0;
    idleCycles(2);
    checkAllZero("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("ready before first edge", {31'b0, bus.ready_o}, 32'h0);
    idleCycles(1);
    checkOutput("ready after release", {31'b0, bus.ready_o}, 32'h1);

    // Two-word instruction load.
    expectImem(8'h00, 32'h00A00013);
    expectImem(8'h01, 32'h00000033);
    sendFrame('{8'h49, 8'h00, 8'h02, 8'h13, 8'h00, 8'hA0, 8'h00,
                8'h33, 8'h00, 8'h00, 8'h00, 8'h80});
    idleCycles(1);
    checkOutput("chk_err after good I", {31'b0, bus.chk_err_o}, 32'h0);

    // Data load at the top of dmem, then one that would run past the end.
    expectDmem(5'd30, 8'h05);
    expectDmem(5'd31, 8'h07);
    sendFrame('{8'h44, 8'h1E, 8'h02, 8'h05, 8'h07, 8'h02});
    sendFrame('{8'h44, 8'h1F});
    expectErr();
    applyStimulus(8'h02);

    // Data address with high bits set is rejected at the address byte.
    applyStimulus(8'h44);
    expectErr();
    applyStimulus(8'h20);

    // Unknown command.
    expectErr();
    applyStimulus(8'h58);

    // Start control and load lockout while running.
    checkOutput("start before G", {31'b0, bus.start_o}, 32'h0);
    applyStimulus(8'h47);
    checkOutput("start after G", {31'b0, bus.start_o}, 32'h1);
    expectErr();
    applyStimulus(8'h49);
    checkOutput("start held after rejected I", {31'b0, bus.start_o}, 32'h1);
    applyStimulus(8'h53);
    checkOutput("start after S", {31'b0, bus.start_o}, 32'h0);
    expectImem(8'h40, 32'h04030201);
    sendFrame('{8'h49, 8'h40, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});

    // Instruction address wrap 255 -> 0.
    expectImem(8'hFF, 32'h04030201);
    expectImem(8'h00, 32'h08070605);
    sendFrame('{8'h49, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h08});

    // Data load with valid_i paused mid-payload.
    expectDmem(5'd0, 8'hA5);
    sendFrame('{8'h44, 8'h00, 8'h02, 8'hA5});
    idleCycles(3);
    expectDmem(5'd1, 8'h5A);
    sendFrame('{8'h5A, 8'hFF});
    idleCycles(1);
    checkOutput("chk_err after paused D", {31'b0, bus.chk_err_o}, 32'h0);

    // Bad checksum: word still written, sticky flag set.
    expectImem(8'h10, 32'hDDCCBBAA);
    sendFrame('{8'h49, 8'h10, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    expectErr();
    applyStimulus(8'h55);
    checkOutput("chk_err set", {31'b0, bus.chk_err_o}, 32'h1);
    applyStimulus(8'h47);
    idleCycles(2);
    checkOutput("chk_err sticky", {31'b0, bus.chk_err_o}, 32'h1);
    checkOutput("start before reset", {31'b0, bus.start_o}, 32'h1);

    // Reset clears start and the sticky flag.
    rst_n = 1'b0;
    #1;
    checkOutput("start cleared by reset", {31'b0, bus.start_o}, 32'h0);
    checkOutput("chk_err cleared by reset", {31'b0, bus.chk_err_o}, 32'h0);
    idleCycles(1);
    rst_n = 1'b1;
    idleCycles(1);

    // Reset mid-frame discards the partial word.
    sendFrame('{8'h49, 8'h20, 8'h01, 8'h11, 8'h22});
    rst_n = 1'b0;
    #1;
    checkAllZero("mid-frame reset");
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    expectImem(8'h05, 32'h44332211);
    sendFrame('{8'h49, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    idleCycles(4);
    checkOutput("chk_err after reload", {31'b0, bus.chk_err_o}, 32'h0);
    checkOutput("outstanding expected events", expQ.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
